cmd_queue_sched: RTL and testbench
==================================

# cmd_queue_sched

Command queue and scheduler between the BLE UART receiver and the command processor. Captures each 16-bit command word from the UART wrapper, performs the `cmd_rdy`/`clr_cmd_rdy` handshake, and buffers words in a small FIFO. It presents the oldest word to the command processor on a ready/ack interface, so the processor can take the next command without stalling on the UART. It also reports occupancy and overflow.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2 and ≥ 2.
- `CW`, 16: command word width.
- `clk` in 1: operational clock; all flops on posedge.
- `rst` in 1: reset, asynchronous and active-high.
- `uart_cmd` in CW: command word from the UART wrapper; valid while `uart_cmd_rdy` is high.
- `uart_cmd_rdy` in 1: UART has a complete word.
- `uart_clr_cmd_rdy` out 1: one-cycle pulse that clears the UART ready flag.
- `nxt_cmd` out CW: head-of-queue word (first-word fall-through).
- `nxt_rdy` out 1: queue non-empty; `nxt_cmd` is valid.
- `nxt_ack` in 1: consumer takes the head word.
- `flush` in 1: synchronous queue clear.
- `count` out $clog2(DEPTH+1): current occupancy.
- `full` out 1: count == DEPTH.
- `overflow` out 1: sticky; a word was dropped because the queue was full.
- `stop` out 1: one-cycle pulse on stop-word reception (see Configuration).

## Operation
- Capture FSM states:
  - **WAIT_RDY**: if `uart_cmd_rdy` is high, sample `uart_cmd` and go to CLR.
  - **CLR**: assert `uart_clr_cmd_rdy` for exactly this cycle, then go to WAIT_LOW.
  - **WAIT_LOW**: stay until `uart_cmd_rdy` is low, then go to WAIT_RDY.
- **Push**: occurs on the WAIT_RDY→CLR transition if not full, or if full with a pop in the same cycle. If full with no pop, the word is dropped, `overflow` is set, and the handshake still completes.
- **Pop**: `nxt_ack & nxt_rdy`. `nxt_ack` while empty is ignored.
- **Simultaneous push and pop**: both occur; `count` is unchanged.
  - At full, the pushed word is accepted.
  - At empty, there is no pop; the pushed word becomes the head.
- **Flush**: pointers, `count` and `overflow` are cleared in one cycle. Flush has priority over push and pop; a word captured in the same cycle is dropped but its UART handshake still completes. The FSM state is not affected by flush.
- **Pointers**: log2(DEPTH)+1 bits each, wrapping naturally.
  - `full` = MSBs differ and the rest are equal.
  - `nxt_rdy` = pointers unequal.
- **Reset** values:
  - FSM = WAIT_RDY.
  - Pointers, `count`, `overflow`, `stop`, `uart_clr_cmd_rdy` = 0.
  - `nxt_rdy` = 0, `full` = 0.
  - `nxt_cmd` = 0; storage is reset to 0.
- **Reset mid-handshake** (in CLR or WAIT_LOW): return to WAIT_RDY. A word still flagged by the UART is re-captured once; this is acceptable.

## Timing
- `uart_cmd_rdy` high in cycle N (FSM in WAIT_RDY):
  - Word written at the edge ending N.
  - `uart_clr_cmd_rdy` high in N+1.
  - `nxt_rdy`/`nxt_cmd` valid in N+1 if the queue was empty.
- Earliest next capture: the first cycle after `uart_cmd_rdy` is observed low in WAIT_LOW.
- Pop: `nxt_ack` sampled at edge; the next word appears on `nxt_cmd` in the following cycle. Back-to-back acks are allowed, one pop per cycle.
- `count`, `full` and `overflow` update at the same edge as the push, pop or flush that changes them.
- `stop` is high for one cycle: the cycle after the capture.

## Configuration
- `CMD_QUEUE_STOP_EN` defined: a captured word equal to `STOP_WORD` (16'h0000) is not enqueued. Instead, the queue is flushed exactly as for `flush` and `stop` pulses in N+1. The UART handshake is unchanged.
- Undefined: 16'h0000 is enqueued like any other word, and `stop` is tied 0.

## Structure
- Package `cmd_queue_pkg` holds:
  - the capture-FSM state enum (WAIT_RDY, CLR, WAIT_LOW);
  - `STOP_WORD`;
  - default `DEPTH`/`CW` constants.
- Sub-module `cmd_fifo`: storage array, read/write pointers, `count`/`full`/empty, and flush. The top level holds the capture FSM, push/pop qualification, `overflow` and `stop`.

## Test plan
- **Single word**: send 16'h00C5 → `uart_clr_cmd_rdy` pulses 1 cycle; `nxt_rdy`=1 and `nxt_cmd`=16'h00C5 one cycle after capture; ack → `nxt_rdy`=0, `count`=0.
- **Fill and overflow** (DEPTH=4): send 16'h0001..16'h0005 with no acks → `full`=1 after 4; 5th dropped; `overflow`=1; all 5 `uart_clr_cmd_rdy` pulses seen; acks drain 1,2,3,4 in order.
- **Full with simultaneous push and pop**: hold full, capture 16'h0007 in the same cycle as `nxt_ack` → `count` stays 4, no overflow, 16'h0007 is last out.
- **Flush**: 3 queued plus `flush` in a capture cycle → `count`=0, `overflow`=0, captured word lost, handshake completes; pointer wrap checked after 10 further push/pop pairs.
- **Reset mid-operation**: assert `rst` in WAIT_LOW with 2 words queued → all outputs 0 immediately; after release, FSM is in WAIT_RDY and captures the next word normally.
- **Stop word**: with `CMD_QUEUE_STOP_EN` defined, 2 queued then 16'h0000 → queue empty and `stop` pulses 1 cycle. Without the macro → `count`=3 and `stop` stays 0.

Source files
------------

// File: rtl/cmd_queue_pkg.sv
// Shared types and constants for the UART command queue: capture FSM states,
// the stop word and default sizing.
package cmd_queue_pkg;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    CLR      = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_t;

  localparam logic [15:0] STOP_WORD     = 16'h0000;
  localparam int          DEFAULT_DEPTH = 4;
  localparam int          DEFAULT_CW    = 16;

endpackage

// File: rtl/cmd_fifo.sv
// First-word fall-through FIFO with extra-MSB pointers, occupancy count and a
// synchronous flush that overrides push and pop.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [CW-1:0]                  wdata,
  input  logic                           pop,
  output logic [CW-1:0]                  rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [CW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // A push at full is only issued together with a pop, so writing the slot
  // under rd_ptr is safe: its old word is consumed at this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = CNTW'(wr_ptr - rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/cmd_queue_sched.sv
// Command queue between the BLE UART receiver and the command processor.
// Optional stop-word flush is enabled by defining CMD_QUEUE_STOP_EN.
module cmd_queue_sched
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = DEFAULT_CW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CW-1:0]              uart_cmd,
  input  logic                       uart_cmd_rdy,
  output logic                       uart_clr_cmd_rdy,
  output logic [CW-1:0]              nxt_cmd,
  output logic                       nxt_rdy,
  input  logic                       nxt_ack,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic                       stop,
  output cap_state_t                 cap_state
);

  cap_state_t state_q;
  cap_state_t state_d;
  logic       capture;
  logic       stop_hit;
  logic       fifo_flush;
  logic       push;
  logic       pop;
  logic       empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_RDY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    capture          = 1'b0;
    uart_clr_cmd_rdy = 1'b0;
    case (state_q)
      WAIT_RDY: if (uart_cmd_rdy) begin
        capture = 1'b1;
        state_d = CLR;
      end
      CLR: begin
        uart_clr_cmd_rdy = 1'b1;
        state_d          = WAIT_LOW;
      end
      WAIT_LOW: if (!uart_cmd_rdy) state_d = WAIT_RDY;
      default:  state_d = WAIT_RDY;
    endcase
  end

  assign cap_state = state_q;

`ifdef CMD_QUEUE_STOP_EN
  assign stop_hit = capture && (uart_cmd == CW'(STOP_WORD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stop <= 1'b0;
    else     stop <= stop_hit;
  end
`else
  assign stop_hit = 1'b0;
  assign stop     = 1'b0;
`endif

  // Consumer side: nxt_cmd is valid whenever nxt_rdy is high; a word is
  // transferred on every rising edge where nxt_rdy and nxt_ack are both high.
  assign nxt_rdy    = !empty;
  assign fifo_flush = flush || stop_hit;
  assign pop        = nxt_ack && nxt_rdy && !fifo_flush;
  assign push       = capture && !stop_hit && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              overflow <= 1'b0;
    else if (fifo_flush)                  overflow <= 1'b0;
    else if (capture && full && !pop)     overflow <= 1'b1;
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (push),
    .wdata (uart_cmd),
    .pop   (pop),
    .rdata (nxt_cmd),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_cmd_queue_sched.sv
// Self-checking bench for cmd_queue_sched: directed scenarios plus a random
// mix of UART words, acks and flushes checked against a queue model.
module tb_cmd_queue_sched;
  import cmd_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int CNTW  = $clog2(DEPTH + 1);

`ifdef CMD_QUEUE_STOP_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CW-1:0]   uart_cmd = '0;
  logic            uart_cmd_rdy = 1'b0;
  logic            uart_clr_cmd_rdy;
  logic [CW-1:0]   nxt_cmd;
  logic            nxt_rdy;
  logic            nxt_ack = 1'b0;
  logic            flush = 1'b0;
  logic [CNTW-1:0] count;
  logic            full;
  logic            overflow;
  logic            stop;
  cap_state_t      cap_state;

  logic [CW-1:0]   exp_q[$];
  logic            exp_ovf = 1'b0;
  int              vectors = 0;
  int              miscompares = 0;
  int              clr_pulses = 0;

  cmd_queue_sched #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .uart_cmd         (uart_cmd),
    .uart_cmd_rdy     (uart_cmd_rdy),
    .uart_clr_cmd_rdy (uart_clr_cmd_rdy),
    .nxt_cmd          (nxt_cmd),
    .nxt_rdy          (nxt_rdy),
    .nxt_ack          (nxt_ack),
    .flush            (flush),
    .count            (count),
    .full             (full),
    .overflow         (overflow),
    .stop             (stop),
    .cap_state        (cap_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rand_word();
    return CW'($urandom_range(1, 16'hFFFF));
  endfunction

  // Full UART handshake for one word; ack/flush are applied in the capture cycle.
  task automatic uart_send(input logic [CW-1:0] w, input bit a, input bit f);
    logic            exp_stop;
    logic [CNTW-1:0] exp_cnt;
    uart_cmd     = w;
    uart_cmd_rdy = 1'b1;
    nxt_ack      = a;
    flush        = f;
    if (a && !f && exp_q.size() > 0) begin
      vectors++;
      if (nxt_cmd !== exp_q[0]) begin
        miscompares++;
        $display("FAIL acked_word: got %h expected %h", nxt_cmd, exp_q[0]);
      end
    end
    step();
    exp_stop = 1'b0;
    if (f) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else if (STOP_EN && w == STOP_WORD) begin
      exp_q.delete();
      exp_ovf  = 1'b0;
      exp_stop = 1'b1;
    end else begin
      if (a && exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else                      exp_ovf = 1'b1;
    end
    nxt_ack      = 1'b0;
    flush        = 1'b0;
    uart_cmd_rdy = 1'b0;
    exp_cnt      = CNTW'(exp_q.size());
    if (uart_clr_cmd_rdy === 1'b1) clr_pulses++;
    vectors++;
    if (uart_clr_cmd_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_pulse: got %b expected 1", uart_clr_cmd_rdy);
    end
    vectors++;
    if (stop !== exp_stop) begin
      miscompares++;
      $display("FAIL stop_pulse: got %b expected %b", stop, exp_stop);
    end
    vectors++;
    if (count !== exp_cnt || full !== (exp_q.size() == DEPTH) ||
        nxt_rdy !== (exp_q.size() > 0) || overflow !== exp_ovf) begin
      miscompares++;
      $display("FAIL status: got count=%0d full=%b rdy=%b ovf=%b expected count=%0d full=%b rdy=%b ovf=%b",
               count, full, nxt_rdy, overflow, exp_cnt, (exp_q.size() == DEPTH),
               (exp_q.size() > 0), exp_ovf);
    end
    if (exp_q.size() > 0) begin
      vectors++;
      if (nxt_cmd !== exp_q[0]) begin
        miscompares++;
        $display("FAIL head_word: got %h expected %h", nxt_cmd, exp_q[0]);
      end
    end
    step();
    vectors++;
    if (uart_clr_cmd_rdy !== 1'b0 || stop !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: got clr=%b stop=%b expected clr=0 stop=0", uart_clr_cmd_rdy, stop);
    end
    step();
  endtask

  task automatic do_ack();
    logic [CNTW-1:0] exp_cnt;
    nxt_ack = 1'b1;
    if (exp_q.size() > 0) begin
      vectors++;
      if (nxt_cmd !== exp_q[0]) begin
        miscompares++;
        $display("FAIL pop_word: got %h expected %h", nxt_cmd, exp_q[0]);
      end
    end
    step();
    nxt_ack = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_cnt = CNTW'(exp_q.size());
    vectors++;
    if (count !== exp_cnt || nxt_rdy !== (exp_q.size() > 0)) begin
      miscompares++;
      $display("FAIL after_pop: got count=%0d rdy=%b expected count=%0d rdy=%b",
               count, nxt_rdy, exp_cnt, (exp_q.size() > 0));
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    vectors++;
    if (count !== '0 || overflow !== 1'b0 || nxt_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: got count=%0d ovf=%b rdy=%b expected 0 0 0", count, overflow, nxt_rdy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++;
    if (count !== '0 || full !== 1'b0 || nxt_rdy !== 1'b0 || overflow !== 1'b0 ||
        stop !== 1'b0 || uart_clr_cmd_rdy !== 1'b0 || nxt_cmd !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got count=%0d full=%b rdy=%b ovf=%b stop=%b clr=%b cmd=%h expected all 0",
               count, full, nxt_rdy, overflow, stop, uart_clr_cmd_rdy, nxt_cmd);
    end
    vectors++;
    if (cap_state !== WAIT_RDY) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected %0d", cap_state, WAIT_RDY);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_word();
    uart_send(16'h00C5, 1'b0, 1'b0);
    vectors++;
    if (nxt_rdy !== 1'b1 || nxt_cmd !== 16'h00C5) begin
      miscompares++;
      $display("FAIL single_head: got rdy=%b cmd=%h expected rdy=1 cmd=00c5", nxt_rdy, nxt_cmd);
    end
    do_ack();
    vectors++;
    if (nxt_rdy !== 1'b0 || count !== '0) begin
      miscompares++;
      $display("FAIL single_drain: got rdy=%b count=%0d expected 0 0", nxt_rdy, count);
    end
  endtask

  task automatic test_fill_overflow();
    int pulses0;
    do_flush();
    pulses0 = clr_pulses;
    for (int i = 1; i <= 5; i++) begin
      uart_send(CW'(i), 1'b0, 1'b0);
      if (i == 4) begin
        vectors++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_full: got full=%b ovf=%b expected 1 0", full, overflow);
        end
      end
    end
    vectors++;
    if (overflow !== 1'b1 || count !== CNTW'(DEPTH) || clr_pulses - pulses0 != 5) begin
      miscompares++;
      $display("FAIL fill_overflow: got ovf=%b count=%0d pulses=%0d expected 1 4 5",
               overflow, count, clr_pulses - pulses0);
    end
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (nxt_cmd !== CW'(i)) begin
        miscompares++;
        $display("FAIL drain_order: got %h expected %h", nxt_cmd, CW'(i));
      end
      do_ack();
    end
  endtask

  task automatic test_full_push_pop();
    do_flush();
    for (int i = 0; i < DEPTH; i++) uart_send(rand_word(), 1'b0, 1'b0);
    uart_send(16'h0007, 1'b1, 1'b0);
    vectors++;
    if (count !== CNTW'(DEPTH) || overflow !== 1'b0 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_push_pop: got count=%0d ovf=%b full=%b expected 4 0 1", count, overflow, full);
    end
    repeat (DEPTH - 1) do_ack();
    vectors++;
    if (nxt_cmd !== 16'h0007 || count !== CNTW'(1)) begin
      miscompares++;
      $display("FAIL last_out: got cmd=%h count=%0d expected 0007 1", nxt_cmd, count);
    end
    do_ack();
  endtask

  task automatic test_flush();
    int pulses0;
    do_flush();
    for (int i = 0; i < DEPTH + 1; i++) uart_send(rand_word(), 1'b0, 1'b0);
    do_ack();
    pulses0 = clr_pulses;
    uart_send(rand_word(), 1'b0, 1'b1);
    vectors++;
    if (count !== '0 || overflow !== 1'b0 || nxt_rdy !== 1'b0 || clr_pulses - pulses0 != 1) begin
      miscompares++;
      $display("FAIL flush_capture: got count=%0d ovf=%b rdy=%b pulses=%0d expected 0 0 0 1",
               count, overflow, nxt_rdy, clr_pulses - pulses0);
    end
    for (int i = 0; i < 10; i++) begin
      uart_send(rand_word(), 1'b0, 1'b0);
      do_ack();
    end
    vectors++;
    if (count !== '0 || full !== 1'b0 || nxt_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_empty: got count=%0d full=%b rdy=%b expected 0 0 0", count, full, nxt_rdy);
    end
  endtask

  task automatic test_reset_mid();
    do_flush();
    uart_send(rand_word(), 1'b0, 1'b0);
    uart_cmd     = 16'h0A0B;
    uart_cmd_rdy = 1'b1;
    step();
    step();
    vectors++;
    if (cap_state !== WAIT_LOW || count !== CNTW'(2)) begin
      miscompares++;
      $display("FAIL pre_reset: got state=%0d count=%0d expected %0d 2", cap_state, count, WAIT_LOW);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (count !== '0 || nxt_rdy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 ||
        nxt_cmd !== '0 || uart_clr_cmd_rdy !== 1'b0 || stop !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got count=%0d rdy=%b full=%b ovf=%b cmd=%h clr=%b stop=%b expected all 0",
               count, nxt_rdy, full, overflow, nxt_cmd, uart_clr_cmd_rdy, stop);
    end
    vectors++;
    if (cap_state !== WAIT_RDY) begin
      miscompares++;
      $display("FAIL reset_mid_state: got %0d expected %0d", cap_state, WAIT_RDY);
    end
    uart_cmd_rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    step();
    uart_send(16'h1234, 1'b0, 1'b0);
    vectors++;
    if (nxt_cmd !== 16'h1234 || count !== CNTW'(1)) begin
      miscompares++;
      $display("FAIL post_reset_capture: got cmd=%h count=%0d expected 1234 1", nxt_cmd, count);
    end
    do_ack();
  endtask

  task automatic test_stop();
    do_flush();
    uart_send(rand_word(), 1'b0, 1'b0);
    uart_send(rand_word(), 1'b0, 1'b0);
    uart_send(16'h0000, 1'b0, 1'b0);
`ifdef CMD_QUEUE_STOP_EN
    vectors++;
    if (count !== '0 || nxt_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_flush: got count=%0d rdy=%b expected 0 0", count, nxt_rdy);
    end
`else
    vectors++;
    if (count !== CNTW'(3) || stop !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_disabled: got count=%0d stop=%b expected 3 0", count, stop);
    end
`endif
    while (exp_q.size() > 0) do_ack();
  endtask

  task automatic test_random();
    int op;
    logic [CW-1:0] w;
    do_flush();
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        w = ($urandom_range(0, 7) == 0) ? CW'(0) : rand_word();
        uart_send(w, 1'($urandom_range(0, 1)), (op == 0) && ($urandom_range(0, 2) == 0));
      end else begin
        do_ack();
      end
    end
    while (exp_q.size() > 0) do_ack();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    test_stop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
